// File: rtl/uart_loader_pkg.sv
// Shared constants for the UART boot loader: frame bytes, reply codes, FSM state encodings
// and the running checksum helper.
package uart_loader_pkg;

  localparam int BYTE_W = 8;

  localparam logic [7:0] SYNC  = 8'hA5;
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_CMD  = 4'd1;
  localparam logic [3:0] ST_AH   = 4'd2;
  localparam logic [3:0] ST_AL   = 4'd3;
  localparam logic [3:0] ST_CNT  = 4'd4;
  localparam logic [3:0] ST_DH   = 4'd5;
  localparam logic [3:0] ST_DL   = 4'd6;
  localparam logic [3:0] ST_CSUM = 4'd7;
  localparam logic [3:0] ST_RESP = 4'd8;
  localparam logic [3:0] ST_RGRD = 4'd9;

  // Frame checksum is a plain modulo-256 byte sum; a good frame sums to zero.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/uart_loader_if.sv
// Byte-stream (buart) and RAM write-port bundle for the UART boot loader.
// master = loader side, slave = buart/RAM/top side.
interface uart_loader_if
  import uart_loader_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) ();

  logic              rx_valid;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_rd;
  logic              tx_busy;
  logic              tx_wr;
  logic [BYTE_W-1:0] tx_data;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              hold_cpu;

  modport master (
    input  rx_valid, rx_data, tx_busy,
    output rx_rd, tx_wr, tx_data, ram_we, ram_addr, ram_wdata, hold_cpu
  );

  modport slave (
    output rx_valid, rx_data, tx_busy,
    input  rx_rd, tx_wr, tx_data, ram_we, ram_addr, ram_wdata, hold_cpu
  );

endinterface

// File: rtl/uart_loader.sv
// j1 boot loader: parses A5-framed W/G commands from buart, writes RAM words, holds the CPU in reset.
// Optional inter-byte timeout enabled by defining UART_LOADER_TIMEOUT_EN.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int   ADDR_W         = 13,
  parameter int   DATA_W         = 16,
  parameter logic HOLD_AT_RESET  = 1'b1,
  parameter int   TIMEOUT_CYCLES = 1200000
) (
  input  logic          clk,
  input  logic          resetq,
  uart_loader_if.master bus
);

  logic [3:0]        state_r;
  logic              rx_rd_r;
  logic              tx_wr_r;
  logic [7:0]        tx_data_r;
  logic              ram_we_r;
  logic [ADDR_W-1:0] ram_addr_r;
  logic [DATA_W-1:0] ram_wdata_r;
  logic              hold_cpu_r;
  logic [7:0]        count_r;
  logic [7:0]        csum_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        hi_r;
  logic [7:0]        lo_r;
  logic              wr_pend_r;
  logic              ack_r;
  logic              go_r;

  logic              rx_state_s;
  logic              accept_s;
  logic [7:0]        csum_next_s;
  logic [15:0]       addr_full_s;
  logic              to_arm_s;
  logic              timeout_s;

  // Byte acceptance: receive states only, and never in the cycle right after a pop.
  always_comb begin
    rx_state_s = 1'b0;
    to_arm_s   = 1'b0;
    case (state_r)
      ST_IDLE:                                         rx_state_s = 1'b1;
      ST_CMD, ST_AH, ST_AL, ST_CNT, ST_DH, ST_DL, ST_CSUM: begin
        rx_state_s = 1'b1;
        to_arm_s   = 1'b1;
      end
      default: begin
        rx_state_s = 1'b0;
        to_arm_s   = 1'b0;
      end
    endcase
    accept_s    = rx_state_s & bus.rx_valid & ~rx_rd_r;
    csum_next_s = csum_add(csum_r, bus.rx_data);
    addr_full_s = {hi_r, bus.rx_data};
  end

`ifdef UART_LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_r;

  assign timeout_s = to_arm_s && (to_cnt_r == TO_W'(TIMEOUT_CYCLES));

  // Inter-byte silence counter, restarted by every pop and idle outside a frame.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      to_cnt_r <= '0;
    end else if (rx_rd_r || !to_arm_s || timeout_s) begin
      to_cnt_r <= '0;
    end else begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end
  end
`else
  logic unused_cfg_s;
  assign unused_cfg_s = to_arm_s & (TIMEOUT_CYCLES != 0);
  assign timeout_s    = 1'b0;
`endif

  // Frame FSM, checksum accumulator, word/address counters and registered outputs.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_r     <= ST_IDLE;
      rx_rd_r     <= 1'b0;
      tx_wr_r     <= 1'b0;
      tx_data_r   <= 8'h00;
      ram_we_r    <= 1'b0;
      ram_addr_r  <= '0;
      ram_wdata_r <= '0;
      hold_cpu_r  <= HOLD_AT_RESET;
      count_r     <= 8'h00;
      csum_r      <= 8'h00;
      addr_r      <= '0;
      hi_r        <= 8'h00;
      lo_r        <= 8'h00;
      wr_pend_r   <= 1'b0;
      ack_r       <= 1'b0;
      go_r        <= 1'b0;
    end else begin
      rx_rd_r   <= accept_s;
      tx_wr_r   <= 1'b0;
      ram_we_r  <= 1'b0;
      wr_pend_r <= 1'b0;

      // The word write trails the DL byte by one cycle so it lines up after its pop.
      if (wr_pend_r) begin
        ram_we_r    <= 1'b1;
        ram_addr_r  <= addr_r;
        ram_wdata_r <= DATA_W'({hi_r, lo_r});
        addr_r      <= addr_r + ADDR_W'(1);
      end

      if (accept_s) begin
        case (state_r)
          ST_IDLE: begin
            if (bus.rx_data == SYNC) begin
              state_r <= ST_CMD;
              csum_r  <= 8'h00;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_CMD: begin
            csum_r <= bus.rx_data;
            if (bus.rx_data == CMD_W) begin
              state_r    <= ST_AH;
              hold_cpu_r <= 1'b1;
              go_r       <= 1'b0;
            end else if (bus.rx_data == CMD_G) begin
              state_r <= ST_CSUM;
              go_r    <= 1'b1;
            end else begin
              state_r <= ST_RESP;
              ack_r   <= 1'b0;
              go_r    <= 1'b0;
            end
          end
          ST_AH: begin
            csum_r  <= csum_next_s;
            hi_r    <= bus.rx_data;
            state_r <= ST_AL;
          end
          ST_AL: begin
            csum_r  <= csum_next_s;
            addr_r  <= addr_full_s[ADDR_W-1:0];
            state_r <= ST_CNT;
          end
          ST_CNT: begin
            csum_r  <= csum_next_s;
            count_r <= bus.rx_data;
            state_r <= ST_DH;
          end
          ST_DH: begin
            csum_r  <= csum_next_s;
            hi_r    <= bus.rx_data;
            state_r <= ST_DL;
          end
          ST_DL: begin
            // A count of zero decrements through 255 down to 1, giving 256 words.
            csum_r    <= csum_next_s;
            lo_r      <= bus.rx_data;
            wr_pend_r <= 1'b1;
            count_r   <= count_r - 8'd1;
            if (count_r == 8'd1) begin
              state_r <= ST_CSUM;
            end else begin
              state_r <= ST_DH;
            end
          end
          ST_CSUM: begin
            csum_r  <= csum_next_s;
            ack_r   <= (csum_next_s == 8'h00);
            state_r <= ST_RESP;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end else if (timeout_s) begin
        state_r <= ST_IDLE;
      end else begin
        case (state_r)
          ST_RESP: begin
            if (!bus.tx_busy) begin
              tx_wr_r   <= 1'b1;
              tx_data_r <= ack_r ? ACK : NAK;
              state_r   <= ST_RGRD;
            end else begin
              state_r <= ST_RESP;
            end
          end
          ST_RGRD: begin
            if (go_r && ack_r) begin
              hold_cpu_r <= 1'b0;
            end else begin
              hold_cpu_r <= hold_cpu_r;
            end
            state_r <= ST_IDLE;
          end
          default: begin
            state_r <= state_r;
          end
        endcase
      end
    end
  end

  assign bus.rx_rd     = rx_rd_r;
  assign bus.tx_wr     = tx_wr_r;
  assign bus.tx_data   = tx_data_r;
  assign bus.ram_we    = ram_we_r;
  assign bus.ram_addr  = ram_addr_r;
  assign bus.ram_wdata = ram_wdata_r;
  assign bus.hold_cpu  = hold_cpu_r;

endmodule
